// File: rtl/ook_bit_sync.sv
// ook_bit_sync: OOK slicer with adaptive threshold, edge-aligned bit clock recovery and sync-byte framing.
module ook_bit_sync #(
  parameter int          SPS         = 4,
  parameter int          WIN         = 16,
  parameter logic [7:0]  SYNC        = 8'hD5,
  parameter int          FRAME_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_end,
  output logic       sync_found,
  output logic       locked,
  output logic [7:0] thr
);
  localparam int PW = $clog2(SPS);
  localparam int WW = $clog2(WIN);
  localparam int BW = $clog2(FRAME_BYTES + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(SPS - 1);
  localparam logic [PW-1:0] PH_DEC = PW'(SPS / 2);
  localparam logic [WW-1:0] WIN_LAST = WW'(WIN - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(FRAME_BYTES - 1);

  typedef enum logic {HUNT, RECV} state_t;

  state_t state, state_d;
  logic [7:0] max_r, min_r, mx, mn, shreg, nsh;
  logic [8:0] sum;
  logic [WW-1:0] win_cnt;
  logic [PW-1:0] ph, idx;
  logic [2:0] bitcnt;
  logic [BW-1:0] bytecnt;
  logic last_s, s, dec, sync_hit, byte_done, last_byte;

  always_comb begin
    mx = din > max_r ? din : max_r;
    mn = din < min_r ? din : min_r;
    sum = {1'b0, mx} + {1'b0, mn};
    s = din > thr;
    idx = s != last_s ? '0 : ph == PH_LAST ? '0 : ph + 1'b1;
    dec = din_valid && idx == PH_DEC;
    nsh = {shreg[6:0], s};
    sync_hit = dec && state == HUNT && nsh == SYNC;
    byte_done = dec && state == RECV && bitcnt == 3'd7;
    last_byte = byte_done && bytecnt == BYTE_LAST;
    state_d = sync_hit ? RECV : last_byte ? HUNT : state;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= HUNT;
    else state <= state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_out <= 8'h00;
      byte_valid <= 1'b0;
      frame_end <= 1'b0;
      sync_found <= 1'b0;
      locked <= 1'b0;
      thr <= 8'h80;
      shreg <= 8'h00;
      ph <= '0;
      last_s <= 1'b0;
      win_cnt <= '0;
      max_r <= 8'h00;
      min_r <= 8'hFF;
      bitcnt <= '0;
      bytecnt <= '0;
    end else begin
      byte_valid <= byte_done;
      frame_end <= last_byte;
      sync_found <= sync_hit;
      locked <= state_d == RECV;
      if (din_valid) begin
        last_s <= s;
        ph <= idx;
        if (win_cnt == WIN_LAST) begin
          thr <= sum[8:1];
          max_r <= 8'h00;
          min_r <= 8'hFF;
          win_cnt <= '0;
        end else begin
          max_r <= mx;
          min_r <= mn;
          win_cnt <= win_cnt + 1'b1;
        end
      end
      // cleared at frame end so payload tail bits cannot complete a false sync
      if (dec) shreg <= last_byte ? 8'h00 : nsh;
      if (sync_hit) begin
        bitcnt <= '0;
        bytecnt <= '0;
      end else if (dec && state == RECV) begin
        bitcnt <= bitcnt + 1'b1;
        if (byte_done) begin
          byte_out <= nsh;
          bytecnt <= bytecnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ook_bit_sync.sv
// tb_ook_bit_sync: directed checks of thresholding, bit recovery, sync hunting, framing and async reset.
module tb_ook_bit_sync;
  logic clk = 1'b0, rst_n = 1'b0, din_valid = 1'b0, vq = 1'b0;
  logic [7:0] din = 8'h00, hi = 8'h90, lo = 8'h10;
  logic [7:0] byte_out, thr;
  logic byte_valid, frame_end, sync_found, locked;
  int tests = 0, fails = 0, gap = 15, nsamp = 0, syncs = 0, orphan_fe = 0, late = 0;
  logic [8:0] got[$], expq[$];

  ook_bit_sync dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .byte_out(byte_out), .byte_valid(byte_valid), .frame_end(frame_end),
    .sync_found(sync_found), .locked(locked), .thr(thr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) vq <= din_valid;

  always @(negedge clk)
    if (rst_n) begin
      if (byte_valid) got.push_back({frame_end, byte_out});
      if (frame_end && !byte_valid) orphan_fe++;
      if (sync_found) syncs++;
      if ((byte_valid || sync_found) && !vq) late++;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    din = d;
    din_valid = 1'b1;
    nsamp++;
    if (gap > 0) begin
      @(negedge clk);
      din_valid = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic send_bits(input logic [7:0] v, input logic [7:0] st, input int msb, input int lsb);
    for (int i = msb; i >= lsb; i--) repeat (st[i] ? 5 : 4) send(v[i] ? hi : lo);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic [7:0] st);
    send_bits(v, st, 7, 0);
  endtask

  task automatic idle;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic exp_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    expq.push_back({1'b0, a});
    expq.push_back({1'b0, b});
    expq.push_back({1'b0, c});
    expq.push_back({1'b1, d});
  endtask

  task automatic chk_bytes(input string tag);
    chk({tag, "_count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(expq[i]));
    got.delete();
    expq.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_byte_out"}, 32'(byte_out), 'h00);
    chk({tag, "_byte_valid"}, 32'(byte_valid), 'h0);
    chk({tag, "_frame_end"}, 32'(frame_end), 'h0);
    chk({tag, "_sync_found"}, 32'(sync_found), 'h0);
    chk({tag, "_locked"}, 32'(locked), 'h0);
    chk({tag, "_thr"}, 32'(thr), 'h80);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk_reset("por");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) send(i[0] ? 8'h90 : 8'h10);
    chk("thr_before_window", 32'(thr), 'h80);
    send(8'h90);
    chk("thr_after_window", 32'(thr), 'h50);
    // 0x60 only slices high once thr has dropped to 0x50; 0x50 must slice low
    hi = 8'h60;
    lo = 8'h50;
    send_byte(8'hD5, 8'h00);
    idle;
    chk("low_sync", syncs, 1);
    chk("low_locked", 32'(locked), 'h1);
    send_byte(8'h12, 8'h00);
    send_byte(8'h34, 8'h00);
    send_byte(8'h56, 8'h00);
    send_byte(8'h78, 8'h00);
    idle;
    exp_frame(8'h12, 8'h34, 8'h56, 8'h78);
    chk_bytes("low");
    chk("low_sync_once", syncs, 1);
    chk("low_unlocked", 32'(locked), 'h0);
    chk("low_thr", 32'(thr), 'h58);
    hi = 8'h90;
    lo = 8'h10;
    repeat (3) send_byte(8'hAA, 8'h00);
    idle;
    chk("preamble_nosync", syncs, 1);
    send_byte(8'hD5, 8'h00);
    idle;
    chk("preamble_sync", syncs, 2);
    send_byte(8'h12, 8'h00);
    send_byte(8'h34, 8'h00);
    send_byte(8'h56, 8'h00);
    send_byte(8'h78, 8'h00);
    idle;
    exp_frame(8'h12, 8'h34, 8'h56, 8'h78);
    chk_bytes("pre");
    chk("pre_sync_once", syncs, 2);
    chk("pre_thr", 32'(thr), 'h50);
    chk("pre_unlocked", 32'(locked), 'h0);
    send_byte(8'hD5, 8'h00);
    send_byte(8'h12, 8'h00);
    send_byte(8'h34, 8'h00);
    send_byte(8'h56, 8'h00);
    send_byte(8'h78, 8'h60);
    idle;
    exp_frame(8'h12, 8'h34, 8'h56, 8'h78);
    chk_bytes("stretch");
    chk("stretch_sync", syncs, 3);
    while (nsamp % 16 != 0) send(lo);
    chk("pad_thr", 32'(thr), 'h10);
    gap = 0;
    send_byte(8'hD5, 8'h00);
    send_byte(8'h12, 8'h00);
    send_byte(8'hD5, 8'h00);
    send_byte(8'h34, 8'h00);
    send_byte(8'h78, 8'h00);
    send_byte(8'hD5, 8'h00);
    send_byte(8'h9A, 8'h00);
    send_byte(8'hBC, 8'h00);
    send_byte(8'hDE, 8'h00);
    send_byte(8'h21, 8'h00);
    idle;
    gap = 15;
    exp_frame(8'h12, 8'hD5, 8'h34, 8'h78);
    exp_frame(8'h9A, 8'hBC, 8'hDE, 8'h21);
    chk_bytes("b2b");
    chk("b2b_sync", syncs, 5);
    chk("b2b_unlocked", 32'(locked), 'h0);
    send_byte(8'hD5, 8'h00);
    send_bits(8'h12, 8'h00, 7, 4);
    idle;
    chk("mid_locked", 32'(locked), 'h1);
    chk("mid_sync", syncs, 6);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("async");
    @(negedge clk);
    rst_n = 1'b1;
    send_bits(8'h12, 8'h00, 3, 0);
    send_byte(8'h34, 8'h00);
    send_byte(8'h56, 8'h00);
    send_byte(8'h78, 8'h00);
    idle;
    chk("post_rst_no_bytes", got.size(), 0);
    chk("post_rst_no_sync", syncs, 6);
    chk("post_rst_unlocked", 32'(locked), 'h0);
    got.delete();
    for (int i = 0; i < 16; i++) send(i[0] ? 8'hA0 : 8'h20);
    chk("retrain_thr", 32'(thr), 'h60);
    chk("pulse_latency", late, 0);
    chk("orphan_frame_end", orphan_fe, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
